// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: radix-2 shift-add / restoring divide, one bit per edge.
// Latency 33 edges accept->resp_valid (1 for div-by-zero/overflow); req_ready only in IDLE, result held until resp_ready.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_result,
  output logic [TAG_W-1:0] resp_tag
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

  state_t           r_state;
  logic [2:0]       r_op;
  logic [XLEN-1:0]  r_a, r_hi, r_lo, r_result;
  logic             r_neg, r_req_ready, r_resp_valid;
  logic [4:0]       r_cnt;
  logic [TAG_W-1:0] r_tag, r_resp_tag;

  // Operand signedness and magnitude conversion at accept
  logic             w_a_signed, w_b_signed, w_sa, w_sb, w_neg;
  logic [XLEN-1:0]  w_mag_a, w_mag_b;
  logic             w_b_zero, w_ovf, w_special;
  logic [XLEN-1:0]  w_special_res;

  assign w_a_signed = (req_op == 3'b001) || (req_op == 3'b010) ||
                      (req_op == 3'b100) || (req_op == 3'b110);
  assign w_b_signed = (req_op == 3'b001) || (req_op == 3'b100) || (req_op == 3'b110);
  assign w_sa       = w_a_signed & req_a[XLEN-1];
  assign w_sb       = w_b_signed & req_b[XLEN-1];
  assign w_mag_a    = w_sa ? -req_a : req_a;
  assign w_mag_b    = w_sb ? -req_b : req_b;
  // Remainder follows the dividend; products and quotients follow sign(a)^sign(b)
  assign w_neg      = (req_op[2:1] == 2'b11) ? w_sa : (w_sa ^ w_sb);

  assign w_b_zero   = (req_b == '0);
  assign w_ovf      = (req_a == MIN_NEG) && (req_b == ALL_ONE);

  always_comb begin
    w_special     = 1'b0;
    w_special_res = '0;
    if (req_op[2]) begin
      if (w_b_zero) begin
        w_special     = 1'b1;
        w_special_res = req_op[1] ? req_a : ALL_ONE;
      end else if (w_ovf && !req_op[0]) begin
        w_special     = 1'b1;
        w_special_res = req_op[1] ? '0 : MIN_NEG;
      end
    end
  end

  // One iteration: shift-add for multiply, restoring shift-subtract for divide
  logic [XLEN:0]     w_mul_sum, w_div_shift, w_div_diff;
  logic [XLEN-1:0]   w_nhi, w_nlo, w_q_fix, w_r_fix, w_final;
  logic [2*XLEN-1:0] w_prod, w_prod_fix;

  assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
  assign w_div_shift = {r_hi, r_lo[XLEN-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_a};

  always_comb begin
    if (r_op[2]) begin
      w_nhi = w_div_diff[XLEN] ? w_div_shift[XLEN-1:0] : w_div_diff[XLEN-1:0];
      w_nlo = {r_lo[XLEN-2:0], ~w_div_diff[XLEN]};
    end else begin
      w_nhi = w_mul_sum[XLEN:1];
      w_nlo = {w_mul_sum[0], r_lo[XLEN-1:1]};
    end
  end

  assign w_prod     = {w_nhi, w_nlo};
  assign w_prod_fix = r_neg ? -w_prod : w_prod;
  assign w_q_fix    = r_neg ? -w_nlo : w_nlo;
  assign w_r_fix    = r_neg ? -w_nhi : w_nhi;

  always_comb begin
    w_final = '0;
    case (r_op)
      3'b000:                 w_final = w_prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_final = w_prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_final = w_q_fix;
      default:                w_final = w_r_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_op         <= '0;
      r_a          <= '0;
      r_hi         <= '0;
      r_lo         <= '0;
      r_neg        <= 1'b0;
      r_cnt        <= '0;
      r_tag        <= '0;
      r_result     <= '0;
      r_resp_tag   <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid && !flush) begin
            r_op        <= req_op;
            r_tag       <= req_tag;
            r_neg       <= w_neg;
            r_cnt       <= '0;
            r_a         <= req_op[2] ? w_mag_b : w_mag_a;
            r_hi        <= '0;
            r_lo        <= req_op[2] ? w_mag_a : w_mag_b;
            r_req_ready <= 1'b0;
            if (w_special) begin
              r_state      <= S_DONE;
              r_result     <= w_special_res;
              r_resp_tag   <= req_tag;
              r_resp_valid <= 1'b1;
            end else begin
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (flush) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
          end else begin
            r_hi  <= w_nhi;
            r_lo  <= w_nlo;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) begin
              r_state      <= S_DONE;
              r_result     <= w_final;
              r_resp_tag   <= r_tag;
              r_resp_valid <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (flush || resp_ready) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign resp_valid  = r_resp_valid;
  assign resp_result = r_result;
  assign resp_tag    = r_resp_tag;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised and directed checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, req_valid, flush, resp_ready;
  logic        req_ready, resp_valid;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b, resp_result;
  logic [4:0]  req_tag, resp_tag;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_tag(resp_tag)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int     ia, ib;
    longint p;
    logic [63:0] pu;
    ia = a;
    ib = b;
    ref_result = '0;
    case (op)
      3'd0: begin pu = {32'h0, a} * {32'h0, b}; ref_result = pu[31:0]; end
      3'd1: begin p = longint'(ia) * longint'(ib); pu = p; ref_result = pu[63:32]; end
      3'd2: begin p = longint'(ia) * longint'({32'h0, b}); pu = p; ref_result = pu[63:32]; end
      3'd3: begin pu = {32'h0, a} * {32'h0, b}; ref_result = pu[63:32]; end
      3'd4: begin
        if (b == 0) ref_result = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_result = 32'h8000_0000;
        else ref_result = ia / ib;
      end
      3'd5: ref_result = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) ref_result = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_result = 32'h0;
        else ref_result = ia % ib;
      end
      default: ref_result = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    is_special = op[2] && ((b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Issue one request, measure latency, check result/tag, then drain with optional backpressure.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input int hold);
    logic [31:0] exp;
    int          lat, exp_lat;
    bit          rdy_seen;
    exp     = ref_result(op, a, b);
    exp_lat = is_special(op, a, b) ? 1 : 33;
    @(negedge clk);
    req_valid  = 1'b1;
    req_op     = op;
    req_a      = a;
    req_b      = b;
    req_tag    = tag;
    resp_ready = (hold == 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_a     = $urandom;
    req_b     = $urandom;
    req_tag   = 5'($urandom);
    lat       = 1;
    rdy_seen  = 1'b0;
    while (!resp_valid && lat < 100) begin
      if (req_ready) rdy_seen = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    check($sformatf("latency op%0d", op), 64'(lat), 64'(exp_lat));
    check($sformatf("result op%0d a=%h b=%h", op, a, b), {32'h0, resp_result}, {32'h0, exp});
    check("resp_tag", {59'h0, resp_tag}, {59'h0, tag});
    check("req_ready low while busy", {63'h0, rdy_seen | req_ready}, 64'h0);
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clk);
        #1;
        check("held resp_valid", {63'h0, resp_valid}, 64'h1);
        check("held resp_result", {32'h0, resp_result}, {32'h0, exp});
      end
      resp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check("resp_valid drops", {63'h0, resp_valid}, 64'h0);
    check("req_ready back", {63'h0, req_ready}, 64'h1);
    check("result holds", {32'h0, resp_result}, {32'h0, exp});
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       rand_operand = 32'h0;
      1:       rand_operand = 32'h8000_0000;
      2:       rand_operand = 32'hFFFF_FFFF;
      3:       rand_operand = $urandom_range(0, 20);
      4:       rand_operand = -$urandom_range(1, 20);
      default: rand_operand = $urandom;
    endcase
  endfunction

  initial begin
    int seen;
    rst = 1'b1; req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b1;
    req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset req_ready", {63'h0, req_ready}, 64'h1);
    check("reset resp_valid", {63'h0, resp_valid}, 64'h0);
    check("reset resp_result", {32'h0, resp_result}, 64'h0);
    check("reset resp_tag", {59'h0, resp_tag}, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    run_op(3'd0, 32'h7, 32'hFFFF_FFFD, 5'd3, 0);
    run_op(3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 0);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 0);
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 0);
    run_op(3'd4, -32'sd7, 32'd2, 5'd7, 0);
    run_op(3'd6, -32'sd7, 32'd2, 5'd8, 0);
    run_op(3'd5, 32'd100, 32'd7, 5'd9, 0);
    run_op(3'd7, 32'd100, 32'd7, 5'd10, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0);
    run_op(3'd5, 32'h1234, 32'h0, 5'd13, 0);
    run_op(3'd7, 32'h1234, 32'h0, 5'd14, 0);
    run_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd15, 5);

    // flush in IDLE blocks the accept
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd5; req_a = 32'd9; req_b = 32'd3; flush = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0; flush = 1'b0;
    check("flush beats accept", {63'h0, req_ready}, 64'h1);

    // flush mid-BUSY (cnt=10): no response may ever appear
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd5; req_a = 32'hFFFF_0000; req_b = 32'd17; req_tag = 5'd20;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush -> idle", {63'h0, req_ready}, 64'h1);
    seen = 0;
    repeat (40) begin
      if (resp_valid) seen++;
      @(posedge clk);
      #1;
    end
    check("no resp after flush", 64'(seen), 64'h0);
    run_op(3'd5, 32'd9, 32'd3, 5'd21, 0);

    // reset mid-BUSY
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd0; req_a = 32'd5; req_b = 32'd6; req_tag = 5'd22;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid rst req_ready", {63'h0, req_ready}, 64'h1);
    check("mid rst resp_valid", {63'h0, resp_valid}, 64'h0);
    check("mid rst resp_result", {32'h0, resp_result}, 64'h0);
    check("mid rst resp_tag", {59'h0, resp_tag}, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), rand_operand(), rand_operand(),
             5'($urandom), ($urandom_range(0, 3) == 0) ? 2 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
